// File: rtl/change_dispenser.sv
// Coin payout engine: pays a requested amount largest-denomination-first over a
// valid/ready hopper handshake and tracks a saturating stock count per denomination.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a return request
// SELECT  | pick the largest affordable in-stock coin, or finish
// PRESENT | coin offered to the hopper, held until ready
// DONE    | one-cycle completion pulse, residual valid
module change_dispenser #(
    parameter int kNumCoins  = 3,
    parameter int kTotalBits = 31,
    parameter int COIN_VAL0  = 100,
    parameter int COIN_VAL1  = 500,
    parameter int COIN_VAL2  = 1000,
    parameter int STOCK_BITS = 8,
    parameter int INIT_STOCK = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [kNumCoins-1:0]            i_input_coin,
    input  logic                            i_return_req,
    input  logic [kTotalBits-1:0]           i_return_amount,
    output logic                            o_busy,
    output logic [kNumCoins-1:0]            o_return_coin,
    output logic                            o_coin_valid,
    input  logic                            i_coin_ready,
    output logic                            o_done,
    output logic [kTotalBits-1:0]           o_residual,
    output logic [kNumCoins*STOCK_BITS-1:0] o_stock
);

    localparam int kIdxBits = (kNumCoins > 1) ? $clog2(kNumCoins) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_PRESENT,
        S_DONE
    } state_t;

    function automatic logic [kTotalBits-1:0] coin_val(input int k);
        case (k)
            0:       coin_val = kTotalBits'(COIN_VAL0);
            1:       coin_val = kTotalBits'(COIN_VAL1);
            default: coin_val = kTotalBits'(COIN_VAL2);
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [kTotalBits-1:0]   remaining_q, remaining_d;
    logic [kTotalBits-1:0]   residual_q, residual_d;
    logic [kIdxBits-1:0]     coin_idx_q, coin_idx_d;
    logic [kNumCoins-1:0]    return_coin_q, return_coin_d;
    logic                    coin_valid_q, coin_valid_d;
    logic [STOCK_BITS-1:0]   stock_q [kNumCoins];
    logic [STOCK_BITS-1:0]   stock_d [kNumCoins];

    logic                    sel_found;
    logic [kIdxBits-1:0]     sel_idx;
    logic                    handshake;
    logic                    insert_ok;

    // Later (larger) indices overwrite earlier ones, so the highest match wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (coin_val(k) <= remaining_q && stock_q[k] != '0) begin
                sel_found = 1'b1;
                sel_idx   = kIdxBits'(k);
            end
        end
    end

    assign handshake = (state_q == S_PRESENT) && coin_valid_q && i_coin_ready;
    assign insert_ok = (i_input_coin != '0) &&
                       ((i_input_coin & (i_input_coin - kNumCoins'(1))) == '0);

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        residual_d    = residual_q;
        coin_idx_d    = coin_idx_q;
        return_coin_d = return_coin_q;
        coin_valid_d  = coin_valid_q;
        case (state_q)
            S_IDLE: begin
                if (i_return_req) begin
                    remaining_d = i_return_amount;
                    residual_d  = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    coin_idx_d    = sel_idx;
                    return_coin_d = kNumCoins'(1) << sel_idx;
                    coin_valid_d  = 1'b1;
                    state_d       = S_PRESENT;
                end else begin
                    residual_d = remaining_q;
                    state_d    = S_DONE;
                end
            end
            S_PRESENT: begin
                if (handshake) begin
                    remaining_d   = remaining_q - coin_val(int'(coin_idx_q));
                    coin_valid_d  = 1'b0;
                    return_coin_d = '0;
                    state_d       = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Insert and dispense of the same coin in one cycle cancel out.
    always_comb begin
        for (int k = 0; k < kNumCoins; k++) begin
            stock_d[k] = stock_q[k];
            case ({insert_ok && i_input_coin[k], handshake && (coin_idx_q == kIdxBits'(k))})
                2'b10: begin
                    if (stock_q[k] != '1) begin
                        stock_d[k] = stock_q[k] + STOCK_BITS'(1);
                    end
                end
                2'b01: begin
                    stock_d[k] = stock_q[k] - STOCK_BITS'(1);
                end
                default: begin
                    stock_d[k] = stock_q[k];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            residual_q    <= '0;
            coin_idx_q    <= '0;
            return_coin_q <= '0;
            coin_valid_q  <= 1'b0;
            for (int k = 0; k < kNumCoins; k++) begin
                stock_q[k] <= STOCK_BITS'(INIT_STOCK);
            end
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            residual_q    <= residual_d;
            coin_idx_q    <= coin_idx_d;
            return_coin_q <= return_coin_d;
            coin_valid_q  <= coin_valid_d;
            for (int k = 0; k < kNumCoins; k++) begin
                stock_q[k] <= stock_d[k];
            end
        end
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);
    assign o_coin_valid  = coin_valid_q;
    assign o_return_coin = return_coin_q;
    assign o_residual    = residual_q;

    always_comb begin
        o_stock = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            o_stock[k*STOCK_BITS +: STOCK_BITS] = stock_q[k];
        end
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout side of the vending machine coin path.
- Takes a return request (amount in currency units) from the control FSM.
- Pays it out one coin at a time, largest denomination first, to the coin hopper over a valid/ready handshake.
- Keeps a per-denomination coin stock: inserted coins increment it, dispensed coins decrement it. Reports any amount that cannot be paid out.

Parameters:
- kNumCoins, 3, number of denominations; index 0 is the smallest.
- kTotalBits, 31, width of the amount datapath.
- COIN_VAL0, 100, value of coin index 0.
- COIN_VAL1, 500, value of coin index 1.
- COIN_VAL2, 1000, value of coin index 2.
- STOCK_BITS, 8, width of each stock counter; maximum stock = 2^STOCK_BITS-1.
- INIT_STOCK, 8, stock of each denomination after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_input_coin  in  kNumCoins  one-hot pulse when a coin is inserted; adds that coin to stock.
- i_return_req  in  1  request to pay out i_return_amount; sampled only in IDLE.
- i_return_amount  in  kTotalBits  amount to return.
- o_busy  out  1  high in every state except IDLE.
- o_return_coin  out  kNumCoins  one-hot coin being presented; 0 when o_coin_valid=0.
- o_coin_valid  out  1  coin presented to the hopper.
- i_coin_ready  in  1  hopper accepts the presented coin.
- o_done  out  1  one-cycle pulse when payout finishes.
- o_residual  out  kTotalBits  amount left unpaid by the last request.
- o_stock  out  kNumCoins*STOCK_BITS  stock counters; coin k occupies bits [k*STOCK_BITS +: STOCK_BITS].

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; o_busy, o_coin_valid, o_return_coin, o_done, o_residual all 0.
  - remaining=0; every stock counter=INIT_STOCK.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - If i_return_req=1 at an edge: remaining<=i_return_amount, o_residual<=0, go to SELECT.
  - i_return_req is ignored in all other states; no queueing.
- SELECT (one cycle):
  - Choose the highest index k with COIN_VALk <= remaining and stock[k] > 0.
  - If found: latch k, o_return_coin<=onehot(k), o_coin_valid<=1, go to PRESENT.
  - If none (including remaining=0): o_residual<=remaining, go to DONE.
- PRESENT:
  - o_coin_valid and o_return_coin are held stable while i_coin_ready=0.
  - On an edge with valid&&ready: remaining<=remaining-COIN_VALk, stock[k] decrements by 1, o_coin_valid<=0, o_return_coin<=0, go to SELECT.
- DONE (one cycle): o_done=1, then return to IDLE. o_residual holds until the next request is accepted.
- Cost per coin is 2 cycles (SELECT+PRESENT) with i_coin_ready tied high.
  - Example: request accepted at edge 0 gives the first o_coin_valid after edge 1.
  - An N-coin payout with ready=1 has o_done high after edge 2N+1 and IDLE after edge 2N+2.
- Stock update:
  - i_input_coin is honoured in every state, including during a payout.
  - Increment saturates at 2^STOCK_BITS-1.
  - Same coin inserted and dispensed in the same cycle gives net 0.
  - i_input_coin that is not one-hot (0 or multi-hot) is ignored entirely.
- Arithmetic:
  - Subtraction never underflows, because selection guarantees COIN_VALk <= remaining.
  - Amounts that are not a multiple of COIN_VAL0 leave a nonzero residual.
- Reset during PRESENT: o_coin_valid drops asynchronously; the coin is not counted and stock returns to INIT_STOCK.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; o_stock shows 8 for each denomination; o_busy=0.
- amount=1600, ready=1 -> coins 3'b100, 3'b010, 3'b001 presented after edges 1, 3, 5; o_done after edge 7; o_residual=0; stocks 7/7/7.
- amount=1050, ready held low 5 cycles at the first coin -> 3'b100 held stable with valid=1 for all 5 cycles, then one handshake; then o_done with o_residual=50.
- amount=20000 with ready=1 -> 8×3'b100, then 8×3'b010, then 8×3'b001 (24 coins); o_residual=7200; all stocks 0.
- During PRESENT of coin 2, pulse i_input_coin=3'b100 in the handshake cycle -> stock[2] unchanged; in IDLE with stock at 255, insert coin -> stays 255; i_input_coin=3'b011 -> no change.
- Assert reset_n=0 mid-PRESENT -> o_coin_valid=0 immediately; after release, state IDLE and stocks back to 8; a new 500 request pays one 3'b010.
